// File: rtl/div32_iter.sv
// div32_iter: iterative restoring divider, signed or unsigned, with alu32-style flags.
// Latency: start accepted at edge 0, done pulses after edge WIDTH+1 (after edge 2 when B==0).
// Backpressure: none; start is ignored while busy, results are held until the next accepted start.
// Ports: clock, reset_n (async, active-low); start, signed_op, A, B in;
//        busy, done, quotient, remainder, div_by_zero, overflow, zero, negative out.
module div32_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dvd;     // dividend magnitude; quotient bits shift in from the right
   logic [WIDTH-1:0] dsr;     // divisor magnitude
   logic [WIDTH-1:0] rem;     // working remainder magnitude
   logic [WIDTH-1:0] a_raw;   // original dividend, returned as remainder on divide by zero
   logic             sign_a, sign_q, dbz, ovf;

   logic             a_neg, b_neg, step_ge, last_step;
   logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;
   logic [WIDTH:0]   rem_sh, trial;

   assign a_neg = signed_op & A[WIDTH-1];
   assign b_neg = signed_op & B[WIDTH-1];
   assign a_mag = a_neg ? (~A + ONE) : A;
   assign b_mag = b_neg ? (~B + ONE) : B;

   // One restoring step, done at WIDTH+1 bits so a divisor with its MSB set
   // (e.g. |MIN| in signed mode) still compares correctly.
   assign rem_sh    = {rem, dvd[WIDTH-1]};
   assign trial     = rem_sh - {1'b0, dsr};
   assign step_ge   = ~trial[WIDTH];
   assign last_step = (count == CW'(WIDTH - 1));

   always_comb begin
      q_fin = sign_q ? (~dvd + ONE) : dvd;
      r_fin = sign_a ? (~rem + ONE) : rem;
      if (dbz) begin
         q_fin = {WIDTH{1'b1}};
         r_fin = a_raw;
      end else if (ovf) begin
         q_fin = MIN_VAL;
         r_fin = '0;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_step) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count       <= '0;
         dvd         <= '0;
         dsr         <= '0;
         rem         <= '0;
         a_raw       <= '0;
         sign_a      <= 1'b0;
         sign_q      <= 1'b0;
         dbz         <= 1'b0;
         ovf         <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         zero        <= 1'b0;
         negative    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd    <= a_mag;
                  dsr    <= b_mag;
                  rem    <= '0;
                  a_raw  <= A;
                  sign_a <= a_neg;
                  sign_q <= a_neg ^ b_neg;
                  dbz    <= (B == '0);
                  ovf    <= signed_op && (A == MIN_VAL) && (B == {WIDTH{1'b1}});
                  // A zero divisor skips the iterations: preloading the count
                  // makes RUN last a single edge, so done follows two edges
                  // after start. That step's datapath result is discarded.
                  count  <= (B == '0) ? CW'(WIDTH - 1) : '0;
               end
            end
            RUN: begin
               rem   <= step_ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
               dvd   <= {dvd[WIDTH-2:0], step_ge};
               count <= count + CW'(1);
            end
            FIX: begin
               done        <= 1'b1;
               quotient    <= q_fin;
               remainder   <= r_fin;
               div_by_zero <= dbz;
               overflow    <= ovf;
               zero        <= (q_fin == '0);
               negative    <= q_fin[WIDTH-1];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div32_iter.sv
`timescale 1ns/1ps
module tb_div32_iter;
   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         signed_op = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy, done, div_by_zero, overflow, zero, negative;
   logic [W-1:0] quotient, remainder;
   logic [2*W+3:0] res;

   int checks = 0;
   int errors = 0;
   int proto_bad = 0;

   always #5 clock = ~clock;

   div32_iter #(.WIDTH(W)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .signed_op(signed_op),
      .A(A), .B(B), .busy(busy), .done(done), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow),
      .zero(zero), .negative(negative)
   );

   assign res = {quotient, remainder, div_by_zero, overflow, zero, negative};

   // Reference model: plain integer division semantics (truncate toward zero,
   // remainder follows the dividend), plus the special divide-by-zero and
   // signed-overflow results.
   function automatic logic [2*W+3:0] expect_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic s);
      logic [W-1:0] q, r;
      logic dz, ov;
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      dz = 1'b0;
      ov = 1'b0;
      if (b == '0) begin
         dz = 1'b1; q = {W{1'b1}}; r = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         ov = 1'b1; q = 32'h8000_0000; r = '0;
      end else if (s) begin
         q = W'(sa / sb); r = W'(sa % sb);
      end else begin
         q = a / b; r = a % b;
      end
      return {q, r, dz, ov, (q == '0), q[W-1]};
   endfunction

   // Issue one operation from IDLE (called #1 after an edge) and wait for done.
   // lat = number of edges after the accepting edge at which done was seen, -1 on timeout.
   // Busy/done protocol and output hold violations are accumulated in proto_bad.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat);
      logic [2*W+3:0] held;
      held = res;
      A = a; B = b; signed_op = s; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = -1;
      if (busy !== 1'b1 || done !== 1'b0 || res !== held) proto_bad++;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clock); #1;
         if (done === 1'b1) begin
            lat = i;
            if (busy !== 1'b0) proto_bad++;
            break;
         end
         if (busy !== 1'b1 || res !== held) proto_bad++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (res !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", res);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", busy, done);
      end
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_unsigned();
      int lat;
      proto_bad = 0;
      run_op(32'd100, 32'd7, 1'b0, lat);
      checks++;
      if (lat !== 33) begin
         errors++; $display("FAIL unsigned_latency: got %0d expected 33", lat);
      end
      checks++;
      if (quotient !== 32'd14 || remainder !== 32'd2) begin
         errors++; $display("FAIL unsigned_qr: got q=%0d r=%0d expected q=14 r=2", quotient, remainder);
      end
      checks++;
      if ({div_by_zero, overflow, zero, negative} !== 4'b0000) begin
         errors++; $display("FAIL unsigned_flags: got %b expected 0000",
                            {div_by_zero, overflow, zero, negative});
      end
      checks++;
      if (proto_bad !== 0) begin
         errors++; $display("FAIL unsigned_protocol: got %0d violations expected 0", proto_bad);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || res !== {32'd14, 32'd2, 4'b0000}) begin
         errors++; $display("FAIL done_one_cycle: got done=%b res=%h expected done=0 held", done, res);
      end
   endtask

   task automatic test_signed();
      int lat;
      proto_bad = 0;
      run_op(32'hFFFF_FF9C, 32'd7, 1'b1, lat);
      checks++;
      if (lat !== 33) begin
         errors++; $display("FAIL signed_latency: got %0d expected 33", lat);
      end
      checks++;
      if (quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL signed_qr: got q=%h r=%h expected q=fffffff2 r=fffffffe",
                            quotient, remainder);
      end
      checks++;
      if ({div_by_zero, overflow, zero, negative} !== 4'b0001 || proto_bad !== 0) begin
         errors++; $display("FAIL signed_flags: got %b proto=%0d expected 0001 proto=0",
                            {div_by_zero, overflow, zero, negative}, proto_bad);
      end
   endtask

   task automatic test_div_by_zero();
      int lat;
      for (int s = 0; s < 2; s++) begin
         proto_bad = 0;
         run_op(32'h0000_1234, 32'h0, s[0], lat);
         checks++;
         if (lat !== 2) begin
            errors++; $display("FAIL dbz_latency s=%0d: got %0d expected 2", s, lat);
         end
         checks++;
         if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h0000_1234 || div_by_zero !== 1'b1
             || overflow !== 1'b0 || proto_bad !== 0) begin
            errors++; $display("FAIL dbz_result s=%0d: got q=%h r=%h dbz=%b ovf=%b proto=%0d expected ffffffff 1234 1 0 0",
                               s, quotient, remainder, div_by_zero, overflow, proto_bad);
         end
      end
   endtask

   task automatic test_overflow();
      int lat;
      proto_bad = 0;
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
      checks++;
      if (lat !== 33) begin
         errors++; $display("FAIL ovf_latency: got %0d expected 33", lat);
      end
      checks++;
      if (quotient !== 32'h8000_0000 || remainder !== 32'h0 || overflow !== 1'b1
          || negative !== 1'b1 || div_by_zero !== 1'b0 || zero !== 1'b0) begin
         errors++; $display("FAIL ovf_result: got q=%h r=%h ovf=%b neg=%b expected 80000000 0 1 1",
                            quotient, remainder, overflow, negative);
      end
      // Same bit patterns unsigned: an ordinary divide with a zero quotient.
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
      checks++;
      if (res !== expect_res(32'h8000_0000, 32'hFFFF_FFFF, 1'b0) || proto_bad !== 0) begin
         errors++; $display("FAIL ovf_unsigned: got %h expected %h proto=%0d", res,
                            expect_res(32'h8000_0000, 32'hFFFF_FFFF, 1'b0), proto_bad);
      end
   endtask

   task automatic test_back_to_back();
      int lat, lat2;
      A = 32'd100; B = 32'd7; signed_op = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clock); #1;
      end
      A = 32'd5; B = 32'd1; signed_op = 1'b1; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = -1;
      for (int i = 11; i <= 100; i++) begin
         @(posedge clock); #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== 33) begin
         errors++; $display("FAIL ignore_latency: got %0d expected 33", lat);
      end
      checks++;
      if (quotient !== 32'd14 || remainder !== 32'd2) begin
         errors++; $display("FAIL ignore_result: got q=%0d r=%0d expected q=14 r=2", quotient, remainder);
      end
      // Start asserted in the done cycle.
      proto_bad = 0;
      run_op(32'd1000, 32'd3, 1'b0, lat2);
      checks++;
      if (lat2 !== 33 || quotient !== 32'd333 || remainder !== 32'd1 || proto_bad !== 0) begin
         errors++; $display("FAIL back_to_back: got lat=%0d q=%0d r=%0d proto=%0d expected 33 333 1 0",
                            lat2, quotient, remainder, proto_bad);
      end
   endtask

   task automatic test_reset_mid();
      int lat, seen;
      A = 32'd100; B = 32'd7; signed_op = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (res !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_mid_outputs: got res=%h busy=%b done=%b expected 0 0 0",
                            res, busy, done);
      end
      seen = 0;
      repeat (2) begin
         @(posedge clock); #1;
         if (done !== 1'b0) seen++;
      end
      reset_n = 1'b1;
      repeat (40) begin
         @(posedge clock); #1;
         if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen);
      end
      proto_bad = 0;
      run_op(32'd7, 32'd100, 1'b0, lat);
      checks++;
      if (lat !== 33 || quotient !== 32'd0 || remainder !== 32'd7 || zero !== 1'b1
          || negative !== 1'b0 || proto_bad !== 0) begin
         errors++; $display("FAIL after_reset_op: got lat=%0d q=%0d r=%0d zero=%b proto=%0d expected 33 0 7 1 0",
                            lat, quotient, remainder, zero, proto_bad);
      end
   endtask

   task automatic test_random();
      int lat;
      logic [W-1:0] a, b;
      logic s;
      logic [2*W+3:0] exp_r;
      proto_bad = 0;
      for (int n = 0; n < 40; n++) begin
         a = (n % 3 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
         case ($urandom_range(0, 5))
            0:       b = $urandom_range(1, 15);
            1:       b = ~($urandom_range(0, 14));
            2:       b = '0;
            3:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         s = $urandom_range(0, 1);
         exp_r = expect_res(a, b, s);
         run_op(a, b, s, lat);
         checks++;
         if (res !== exp_r) begin
            errors++; $display("FAIL random_result a=%h b=%h s=%b: got %h expected %h", a, b, s, res, exp_r);
         end
         checks++;
         if (lat !== ((b == '0) ? 2 : 33)) begin
            errors++; $display("FAIL random_latency a=%h b=%h: got %0d expected %0d",
                               a, b, lat, (b == '0) ? 2 : 33);
         end
      end
      checks++;
      if (proto_bad !== 0) begin
         errors++; $display("FAIL random_protocol: got %0d violations expected 0", proto_bad);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_by_zero();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
